bcd2bin: RTL and testbench

Sequential 4-digit BCD-to-binary converter: the inverse of the `bin2bcd` unit in the period-measurement datapath. It takes a decimal value entered as BCD digits and produces a 14-bit binary value, for example a test period loaded into `sq_gen` or a divisor constant. It sits on the same 50 MHz clock as the other accelerator units. It exposes the team's standard start/ready/done handshake so the Nios firmware can drive it through a PIO command bit and poll status.

---
 rtl/bcd2bin.sv | 121 ++++++++++++
 tb/tb_bcd2bin.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/bcd2bin.sv
// bcd2bin: sequential 4-digit BCD to 14-bit binary converter.
// Uses reverse double-dabble: 14 right shifts of a {bcd, bin} register,
// with a subtract-3 correction on every BCD digit that reaches 8 or more
// after the shift. Start/ready/done handshake for firmware polling.
module bcd2bin (
  input  logic        iCLK,
  input  logic        iRESET,
  input  logic        iSTART,
  input  logic [3:0]  iBCD3,
  input  logic [3:0]  iBCD2,
  input  logic [3:0]  iBCD1,
  input  logic [3:0]  iBCD0,
  output logic        oREADY,
  output logic        oDONE,
  output logic        oERR,
  output logic [13:0] oBIN
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OP   = 2'd1,
    DONE = 2'd2
  } state_t;

  // Iteration index of the last shift; 14 shifts in total (n = 0..13).
  localparam logic [3:0] LAST_ITER = 4'd13;

  state_t      r_state;
  logic [15:0] r_bcd;
  logic [13:0] r_bin;
  logic [3:0]  r_n;
  logic        r_err;

  logic        w_digits_ok;
  logic [29:0] w_shift;
  logic [15:0] w_bcd_nxt;
  logic [13:0] w_bin_nxt;

  // A BCD digit is legal only in the range 0..9.
  function automatic logic digit_ok(input logic [3:0] d);
    return (d <= 4'd9);
  endfunction

  // Reverse double-dabble correction: after a right shift, a digit that
  // holds 8 or more carried a borrow of "10/2 = 5" instead of "16/2 = 8",
  // so 3 is removed. Plain 4-bit arithmetic, no inter-digit carry.
  function automatic logic [3:0] dabble_fix(input logic [3:0] d);
    return (d >= 4'd8) ? (d - 4'd3) : d;
  endfunction

  // Digit range check on the live inputs, used only at the accepting edge.
  always_comb begin
    w_digits_ok = digit_ok(iBCD3) && digit_ok(iBCD2) &&
                  digit_ok(iBCD1) && digit_ok(iBCD0);
  end

  // One conversion step: shift {bcd, bin} right by one (zero enters the
  // bcd MSB, bcd LSB enters the bin MSB), then correct each digit.
  always_comb begin
    w_shift   = {1'b0, r_bcd, r_bin[13:1]};
    w_bin_nxt = w_shift[13:0];
    w_bcd_nxt = {dabble_fix(w_shift[29:26]),
                 dabble_fix(w_shift[25:22]),
                 dabble_fix(w_shift[21:18]),
                 dabble_fix(w_shift[17:14])};
  end

  // Control FSM and datapath registers; oBIN/oERR hold from DONE until
  // the next accepted request, and a reset clears everything.
  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      r_state <= IDLE;
      r_bcd   <= 16'd0;
      r_bin   <= 14'd0;
      r_n     <= 4'd0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (iSTART) begin
            if (w_digits_ok) begin
              r_bcd   <= {iBCD3, iBCD2, iBCD1, iBCD0};
              r_bin   <= 14'd0;
              r_n     <= 4'd0;
              r_err   <= 1'b0;
              r_state <= OP;
            end else begin
              // Illegal digit: report the error without converting.
              r_bin   <= 14'd0;
              r_err   <= 1'b1;
              r_state <= DONE;
            end
          end
        end
        OP: begin
          r_bcd <= w_bcd_nxt;
          r_bin <= w_bin_nxt;
          r_n   <= r_n + 4'd1;
          if (r_n == LAST_ITER) begin
            r_state <= DONE;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Status and result come straight from registers.
  always_comb begin
    oREADY = (r_state == IDLE);
    oDONE  = (r_state == DONE);
    oERR   = r_err;
    oBIN   = r_bin;
  end

endmodule

// File: tb/tb_bcd2bin.sv
// tb_bcd2bin: table-driven directed vectors, hand-written corner-case
// sequences (ignored re-start, mid-operation reset) and a randomized
// back-to-back run checked against an arithmetic reference model.
module tb_bcd2bin;

  logic        iCLK = 1'b0;
  logic        iRESET;
  logic        iSTART;
  logic [3:0]  iBCD3, iBCD2, iBCD1, iBCD0;
  logic        oREADY, oDONE, oERR;
  logic [13:0] oBIN;

  int vectors    = 0;
  int miscompares = 0;

  bcd2bin dut (
    .iCLK   (iCLK),
    .iRESET (iRESET),
    .iSTART (iSTART),
    .iBCD3  (iBCD3),
    .iBCD2  (iBCD2),
    .iBCD1  (iBCD1),
    .iBCD0  (iBCD0),
    .oREADY (oREADY),
    .oDONE  (oDONE),
    .oERR   (oERR),
    .oBIN   (oBIN)
  );

  always #5 iCLK = ~iCLK;

  typedef struct {
    int          d3, d2, d1, d0;
    logic [13:0] exp_bin;
    logic        exp_err;
  } vec_t;

  vec_t tbl[7];

  // Advance to just after the next rising edge: outputs are sampled and
  // inputs are driven here, well away from the active edge.
  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, got, got, exp, exp);
    end
  endtask

  // Reference: decimal value by place weights; any digit above 9 is an error.
  function automatic void ref_model(input int d3, input int d2, input int d1, input int d0,
                                    output logic [13:0] b, output logic e);
    e = (d3 > 9) || (d2 > 9) || (d1 > 9) || (d0 > 9);
    b = e ? 14'd0 : 14'(d3 * 1000 + d2 * 100 + d1 * 10 + d0);
  endfunction

  task automatic set_digits(input int d3, input int d2, input int d1, input int d0);
    iBCD3 = 4'(d3);
    iBCD2 = 4'(d2);
    iBCD1 = 4'(d1);
    iBCD0 = 4'(d0);
  endtask

  // Issue one request from IDLE and check latency, result and return to IDLE.
  task automatic do_req(input string tag, input int d3, input int d2, input int d1, input int d0,
                        input logic [13:0] eb, input logic ee);
    int lat;
    int exp_lat;
    exp_lat = ee ? 1 : 15;
    chk({tag, "_ready_before"}, oREADY, 1);
    set_digits(d3, d2, d1, d0);
    iSTART = 1'b1;
    tick();
    iSTART = 1'b0;
    lat = 1;
    while (!oDONE && lat < 40) begin
      set_digits($urandom_range(0, 15), $urandom_range(0, 15),
                 $urandom_range(0, 15), $urandom_range(0, 15));
      tick();
      lat++;
    end
    chk({tag, "_latency"}, lat, exp_lat);
    chk({tag, "_bin"}, oBIN, eb);
    chk({tag, "_err"}, oERR, ee);
    chk({tag, "_ready_in_done"}, oREADY, 0);
    tick();
    chk({tag, "_done_pulse"}, oDONE, 0);
    chk({tag, "_ready_after"}, oREADY, 1);
    chk({tag, "_bin_hold"}, oBIN, eb);
  endtask

  initial begin
    logic [13:0] eb;
    logic        ee;
    int          dones;
    int          done_at;

    iRESET = 1'b1;
    iSTART = 1'b0;
    set_digits(0, 0, 0, 0);
    tick();
    tick();
    chk("rst_ready", oREADY, 1);
    chk("rst_done", oDONE, 0);
    chk("rst_err", oERR, 0);
    chk("rst_bin", oBIN, 0);
    iRESET = 1'b0;
    tick();

    // Directed vectors
    tbl[0] = '{d3: 9, d2: 9, d1: 9,  d0: 9, exp_bin: 14'h270F, exp_err: 1'b0};
    tbl[1] = '{d3: 1, d2: 2, d1: 3,  d0: 4, exp_bin: 14'h04D2, exp_err: 1'b0};
    tbl[2] = '{d3: 0, d2: 0, d1: 0,  d0: 0, exp_bin: 14'h0000, exp_err: 1'b0};
    tbl[3] = '{d3: 0, d2: 0, d1: 0,  d0: 1, exp_bin: 14'h0001, exp_err: 1'b0};
    tbl[4] = '{d3: 0, d2: 0, d1: 10, d0: 5, exp_bin: 14'h0000, exp_err: 1'b1};
    tbl[5] = '{d3: 0, d2: 0, d1: 4,  d0: 2, exp_bin: 14'h002A, exp_err: 1'b0};
    tbl[6] = '{d3: 15, d2: 0, d1: 0, d0: 0, exp_bin: 14'h0000, exp_err: 1'b1};
    for (int i = 0; i < 7; i++) begin
      do_req($sformatf("tbl%0d", i), tbl[i].d3, tbl[i].d2, tbl[i].d1, tbl[i].d0,
             tbl[i].exp_bin, tbl[i].exp_err);
    end

    // Re-start pulses during OP and during DONE must be ignored.
    set_digits(5, 0, 0, 0);
    iSTART = 1'b1;
    tick();
    iSTART = 1'b0;
    set_digits(1, 1, 1, 1);
    dones = 0;
    done_at = -1;
    for (int c = 1; c <= 40; c++) begin
      if (oDONE) begin
        dones++;
        done_at = c;
        chk("restart_bin_at_done", oBIN, 14'h1388);
      end
      iSTART = (c == 2 || c == 14) ? 1'b1 : 1'b0;
      tick();
    end
    iSTART = 1'b0;
    chk("restart_done_count", dones, 1);
    chk("restart_done_cycle", done_at, 15);
    chk("restart_bin_final", oBIN, 14'h1388);
    chk("restart_err", oERR, 0);
    chk("restart_ready", oREADY, 1);

    // Reset in the middle of a conversion aborts with no done pulse.
    set_digits(8, 7, 6, 5);
    iSTART = 1'b1;
    tick();
    iSTART = 1'b0;
    for (int c = 1; c < 7; c++) begin
      chk("rstmid_busy", oREADY, 0);
      if (c == 6) iRESET = 1'b1;
      tick();
    end
    iRESET = 1'b0;
    chk("rstmid_ready", oREADY, 1);
    chk("rstmid_bin", oBIN, 0);
    chk("rstmid_err", oERR, 0);
    dones = 0;
    for (int c = 0; c < 20; c++) begin
      if (oDONE) dones++;
      tick();
    end
    chk("rstmid_no_done", dones, 0);
    ref_model(8, 7, 6, 5, eb, ee);
    chk("model_8765", eb, 14'h223D);
    do_req("fresh_8765", 8, 7, 6, 5, eb, ee);

    // Back-to-back with iSTART held high; digits are scrambled while busy.
    begin
      logic [13:0] qb[$];
      logic        qe[$];
      int          issued;
      int          cyc;
      int          last_acc;
      logic        last_err;
      int          d[4];
      issued = 0;
      cyc = 0;
      last_acc = 0;
      last_err = 1'b0;
      while ((issued < 200 || qb.size() > 0) && cyc < 8000) begin
        if (oDONE) begin
          if (qb.size() == 0) begin
            chk("held_spurious_done", 1, 0);
          end else begin
            eb = qb.pop_front();
            ee = qe.pop_front();
            chk("held_bin", oBIN, eb);
            chk("held_err", oERR, ee);
          end
        end
        if (oREADY) begin
          if (issued < 200) begin
            if (issued < 100) begin
              d[3] = 0; d[2] = 0; d[1] = issued / 10; d[0] = issued % 10;
            end else begin
              for (int k = 0; k < 4; k++) d[k] = $urandom_range(0, 9);
              if ($urandom_range(0, 9) == 0) d[$urandom_range(0, 3)] = $urandom_range(10, 15);
            end
            if (issued > 0) chk("held_spacing", cyc - last_acc, last_err ? 2 : 16);
            set_digits(d[3], d[2], d[1], d[0]);
            ref_model(d[3], d[2], d[1], d[0], eb, ee);
            qb.push_back(eb);
            qe.push_back(ee);
            last_acc = cyc;
            last_err = ee;
            issued++;
            iSTART = 1'b1;
          end else begin
            iSTART = 1'b0;
          end
        end else begin
          set_digits($urandom_range(0, 15), $urandom_range(0, 15),
                     $urandom_range(0, 15), $urandom_range(0, 15));
        end
        tick();
        cyc++;
      end
      iSTART = 1'b0;
      chk("held_all_issued", issued, 200);
      chk("held_all_done", qb.size(), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
